// File: rtl/regfile_init_dp.sv
// regfile_init_dp: two-read/two-write register file with a post-reset init sweep.
// Ports: clk, reset (sync, active-high); srcA/srcB -> valA/valB combinational reads;
//        dstE/valE and dstM/valM clocked writes (M wins on collision);
//        ready high once the sweep is done; err_addr pulses after an illegal write.
// Macro REGFILE_WRITE_BYPASS_EN: reads see same-cycle writes; undefined, reads see pre-write contents.
module regfile_init_dp #(
  parameter int                 DATA_W   = 64,
  parameter int                 NREGS    = 15,
  parameter int                 ADDR_W   = 4,
  parameter logic [ADDR_W-1:0]  NONE_ID  = {ADDR_W{1'b1}},
  parameter logic [ADDR_W-1:0]  RSP_ID   = ADDR_W'(4),
  parameter logic [DATA_W-1:0]  RSP_INIT = '0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [ADDR_W-1:0] srcA,
  input  logic [ADDR_W-1:0] srcB,
  output logic [DATA_W-1:0] valA,
  output logic [DATA_W-1:0] valB,
  input  logic [ADDR_W-1:0] dstE,
  input  logic [DATA_W-1:0] valE,
  input  logic [ADDR_W-1:0] dstM,
  input  logic [DATA_W-1:0] valM,
  output logic              ready,
  output logic              err_addr
);
  localparam logic [ADDR_W-1:0] LAST = ADDR_W'(NREGS - 1);
  typedef enum logic {INIT, RUN} state_t;
  state_t            state_q, state_d;
  logic [ADDR_W-1:0] idx_q, idx_d;
  logic              err_q, err_d;
  logic [DATA_W-1:0] file_q [NREGS];
  logic              run, ok_e, ok_m, we_e, we_m, bad;
  assign run  = state_q == RUN;
  assign ok_e = dstE != NONE_ID && dstE <= LAST;
  assign ok_m = dstM != NONE_ID && dstM <= LAST;
  assign we_e = run && ok_e;
  assign we_m = run && ok_m;
  assign bad  = run && ((dstE != NONE_ID && !ok_e) || (dstM != NONE_ID && !ok_m));
  assign ready    = run;
  assign err_addr = err_q;
  always_comb begin
    state_d = (!run && idx_q == LAST) ? RUN : state_q;
    idx_d   = run ? idx_q : idx_q + ADDR_W'(1);
    err_d   = bad;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= INIT;
      idx_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      err_q   <= err_d;
    end
  end
  // Contents are never cleared by reset; the sweep after reset defines them.
  always_ff @(posedge clk) begin
    for (int r = 0; r < NREGS; r++) begin
      if (!reset) begin
        if (!run && idx_q == ADDR_W'(r))
          file_q[r] <= (ADDR_W'(r) == RSP_ID) ? RSP_INIT : '0;
        else if (we_m && dstM == ADDR_W'(r))
          file_q[r] <= valM;
        else if (we_e && dstE == ADDR_W'(r))
          file_q[r] <= valE;
      end
    end
  end
  function automatic logic [DATA_W-1:0] rd(input logic [ADDR_W-1:0] s);
    logic [DATA_W-1:0] v;
    v = '0;
    for (int r = 0; r < NREGS; r++)
      if (s == ADDR_W'(r)) v = file_q[r];
`ifdef REGFILE_WRITE_BYPASS_EN
    // M is checked last so it overrides E when both target the same register.
    if (we_e && s == dstE) v = valE;
    if (we_m && s == dstM) v = valM;
`endif
    if (!run || s == NONE_ID || s > LAST) v = '0;
    return v;
  endfunction
  always_comb valA = rd(srcA);
  always_comb valB = rd(srcB);
endmodule

// File: tb/tb_regfile_init_dp.sv
module tb_regfile_init_dp;
`ifdef REGFILE_WRITE_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif
  localparam logic [3:0] NN = 4'hF;
  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic        reset, ready, err_addr;
  logic [3:0]  srcA, srcB, dstE, dstM;
  logic [63:0] valA, valB, valE, valM;
  logic        b_reset, b_ready, b_err;
  logic [3:0]  b_srcA, b_srcB, b_dstE, b_dstM;
  logic [63:0] b_valA, b_valB, b_valE, b_valM;
  regfile_init_dp #(.RSP_INIT(64'h100)) dut (
    .clk(clk), .reset(reset), .srcA(srcA), .srcB(srcB), .valA(valA), .valB(valB),
    .dstE(dstE), .valE(valE), .dstM(dstM), .valM(valM), .ready(ready), .err_addr(err_addr));
  regfile_init_dp #(.NREGS(8)) dut_b (
    .clk(clk), .reset(b_reset), .srcA(b_srcA), .srcB(b_srcB), .valA(b_valA), .valB(b_valB),
    .dstE(b_dstE), .valE(b_valE), .dstM(b_dstM), .valM(b_valM), .ready(b_ready), .err_addr(b_err));
  typedef struct {
    logic [3:0] de; logic [63:0] ve; logic [3:0] dm; logic [63:0] vm;
    logic [3:0] sa; logic [3:0] sb; logic [63:0] ea; logic [63:0] eb;
  } vec_t;
  vec_t vecs [6];
  vec_t sb_q [$];
  vec_t e;
  logic [63:0] model [8];
  int n_chk = 0, n_fail = 0, cnt;
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", nm, act, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  task automatic wait_ready(input int inj_at, output int c);
    c = 0;
    while (!ready && c < 40) begin
      tick();
      c++;
      if (c == inj_at) begin dstE = 4'd9; valE = 64'h77; dstM = 4'd10; valM = 64'h88; end
      if (c == inj_at + 1) begin dstE = NN; dstM = NN; chk("init_err", {63'b0, err_addr}, 64'd0); end
    end
  endtask
  initial begin
    #200000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1);
  end
  initial begin
    vecs[0] = '{4'd2,  64'hAA,                  4'd5, 64'hBB,                  4'd2, 4'd5, 64'hAA,                  64'hBB};
    vecs[1] = '{4'd7,  64'h11,                  4'd7, 64'h22,                  4'd7, 4'd2, 64'h22,                  64'hAA};
    vecs[2] = '{NN,    64'h5,                   4'd0, 64'h123,                 4'd0, 4'd4, 64'h123,                 64'h100};
    vecs[3] = '{4'd14, 64'hDEAD_BEEF_0000_0001, NN,   64'h0,                   4'd14, NN,  64'hDEAD_BEEF_0000_0001, 64'h0};
    vecs[4] = '{NN,    64'h99,                  NN,   64'h77,                  4'd5, 4'd7, 64'hBB,                  64'h22};
    vecs[5] = '{4'd1,  64'hFFFF_FFFF_FFFF_FFFF, 4'd3, 64'h8000_0000_0000_0000, 4'd1, 4'd3, 64'hFFFF_FFFF_FFFF_FFFF, 64'h8000_0000_0000_0000};
    reset = 1'b1; srcA = 4'd4; srcB = 4'd3; dstE = NN; dstM = NN; valE = '0; valM = '0;
    b_reset = 1'b1; b_srcA = '0; b_srcB = '0; b_dstE = NN; b_dstM = NN; b_valE = '0; b_valM = '0;
    tick(); tick();
    chk("rst_ready", {63'b0, ready}, 64'd0);
    chk("rst_err", {63'b0, err_addr}, 64'd0);
    reset = 1'b0;
    #1;
    chk("init_valA", valA, 64'd0);
    wait_ready(-5, cnt);
    chk("init_cycles", 64'(cnt), 64'd15);
    chk("rsp_init", valA, 64'h100);
    chk("r3_init", valB, 64'h0);
    srcA = NN; #1;
    chk("none_read", valA, 64'h0);
    for (int i = 0; i < 6; i++) begin
      dstE = vecs[i].de; valE = vecs[i].ve; dstM = vecs[i].dm; valM = vecs[i].vm;
      srcA = vecs[i].sa; srcB = vecs[i].sb;
      sb_q.push_back(vecs[i]);
      tick();
      dstE = NN; dstM = NN; #1;
      e = sb_q.pop_front();
      chk($sformatf("vec%0d_A", i), valA, e.ea);
      chk($sformatf("vec%0d_B", i), valB, e.eb);
      chk($sformatf("vec%0d_err", i), {63'b0, err_addr}, 64'd0);
    end
    srcA = 4'd3; srcB = 4'd6; dstE = 4'd3; valE = 64'h55; #1;
    chk("byp_E_same", valA, BYP ? 64'h55 : 64'h8000_0000_0000_0000);
    tick(); dstE = NN; #1;
    chk("byp_E_after", valA, 64'h55);
    dstE = 4'd6; valE = 64'h66; dstM = 4'd6; valM = 64'h77; #1;
    chk("byp_M_same", valB, BYP ? 64'h77 : 64'h0);
    tick(); dstE = NN; dstM = NN; #1;
    chk("byp_M_after", valB, 64'h77);
    srcA = NN; valE = 64'h123; #1;
    chk("byp_none", valA, 64'h0);
    reset = 1'b1; tick(); reset = 1'b0;
    for (int i = 0; i < 6; i++) tick();
    chk("mid_ready", {63'b0, ready}, 64'd0);
    reset = 1'b1; tick(); reset = 1'b0;
    wait_ready(12, cnt);
    chk("restart_cycles", 64'(cnt), 64'd15);
    srcA = 4'd9; srcB = 4'd10; #1;
    chk("init_wr_lost9", valA, 64'h0);
    chk("init_wr_lost10", valB, 64'h0);
    srcA = 4'd1; srcB = 4'd4; #1;
    chk("resweep_r1", valA, 64'h0);
    chk("resweep_rsp", valB, 64'h100);
    b_reset = 1'b0; b_dstE = 4'd9; b_valE = 64'hBAD;
    cnt = 0;
    while (!b_ready && cnt < 40) begin tick(); cnt++; end
    chk("b_init_cycles", 64'(cnt), 64'd8);
    chk("b_init_err", {63'b0, b_err}, 64'd0);
    for (int r = 0; r < 8; r++) begin
      model[r] = {$urandom, $urandom};
      b_dstE = 4'(r); b_valE = model[r];
      tick();
    end
    b_dstE = 4'd9; b_valE = 64'hDEAD;
    tick(); b_dstE = NN; #1;
    chk("b_errE_pulse", {63'b0, b_err}, 64'd1);
    tick();
    chk("b_errE_clear", {63'b0, b_err}, 64'd0);
    b_dstM = 4'd8; b_valM = 64'hBEEF;
    tick(); b_dstM = NN; #1;
    chk("b_errM_pulse", {63'b0, b_err}, 64'd1);
    tick();
    chk("b_errM_clear", {63'b0, b_err}, 64'd0);
    for (int r = 0; r < 8; r++) begin
      b_srcA = 4'(r); #1;
      chk($sformatf("b_reg%0d", r), b_valA, model[r]);
    end
    b_srcB = 4'd9; #1;
    chk("b_oob_read", b_valB, 64'h0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule

// File: doc/regfile_init_dp.md
Name: regfile_init_dp

Overview:
Parametrised successor to the Y86 SEQ decode register file. It provides two asynchronous read ports (A/B) and two clocked write ports (E/M), with M-over-E priority on address collision. After reset, a hardware init sweep loads every register with a defined value. Illegal-address writes raise an error flag. Used by the SEQ and PIPE decode/write-back stages; the file is held in flops, not loaded from or dumped to a text file.

Parameters:
DATA_W, 64, register width in bits
NREGS, 15, number of architectural registers (1..2**ADDR_W-1)
ADDR_W, 4, register-ID width
NONE_ID, 4'hF, ID meaning "no register" (read returns 0, write suppressed)
RSP_ID, 4, register loaded with RSP_INIT by the init sweep
RSP_INIT, 64'h0, stack-pointer init value; all other registers init to 0

Ports:
clk  in  1  clock; all state updates on posedge
reset  in  1  synchronous, active-high reset
srcA  in  ADDR_W  read port A register ID
srcB  in  ADDR_W  read port B register ID
valA  out  DATA_W  port A read data
valB  out  DATA_W  port B read data
dstE  in  ADDR_W  write port E register ID
valE  in  DATA_W  write port E data
dstM  in  ADDR_W  write port M register ID
valM  in  DATA_W  write port M data
ready  out  1  high once the init sweep is complete
err_addr  out  1  one-cycle pulse: the previous cycle attempted an illegal write

Behaviour:
- Clock is clk; reset is synchronous and active-high. Polarity and synchronicity are fixed.
- FSM states are INIT and RUN. While reset is high at a posedge: state goes to INIT, idx goes to 0, ready goes to 0, err_addr goes to 0. Register contents are not touched by reset itself.
- INIT: each cycle writes file[idx] = (idx==RSP_ID ? RSP_INIT : 0), then idx++.
  - When idx==NREGS-1 is written, the next state is RUN and ready goes to 1.
  - Init takes exactly NREGS cycles after reset deasserts.
  - dstE/dstM writes are ignored in INIT and do not raise err_addr.
- Reset asserted mid-INIT or in RUN restarts the sweep at idx 0.
- Reads are combinational.
  - valX = 0 when srcX==NONE_ID, when srcX>=NREGS, or when ready==0.
  - Otherwise valX = file[srcX].
- RUN writes happen on posedge.
  - Port E writes when dstE!=NONE_ID and dstE<NREGS; same rule for port M.
  - If dstE==dstM (valid), only valM is stored.
  - Both ports may write different registers in the same cycle.
- Illegal write: dstE or dstM not equal to NONE_ID and >=NREGS. The write is dropped and err_addr=1 on the next cycle only. Not sticky.
- Read-during-write behaviour is governed by the optional feature below.
- Register widths are exact; there is no sign extension or arithmetic.

Optional Feature:
Macro: REGFILE_WRITE_BYPASS_EN.
- Defined: in RUN, if srcX matches a valid write this cycle, valX returns that write's data (valM if both E and M match). Data is visible in the same cycle, combinationally.
- Undefined: valX returns pre-write contents; new data appears after the posedge.
- Bypass never applies in INIT or for NONE_ID.

Test Plan:
- Reset 1 cycle, default params, RSP_INIT=64'h100 -> ready=0 for 15 cycles then 1; srcA=4 gives 64'h100, srcB=3 gives 0; srcA=F gives 0.
- RUN, dstE=2/valE=64'hAA and dstM=5/valM=64'hBB in the same cycle -> next cycle srcA=2 gives 64'hAA, srcB=5 gives 64'hBB.
- dstE=dstM=7, valE=64'h11, valM=64'h22 -> file[7]=64'h22.
- NREGS=8, dstE=9 -> err_addr=1 exactly one cycle; all registers unchanged.
- Read srcA=3 while dstE=3/valE=64'h55 -> with REGFILE_WRITE_BYPASS_EN defined, valA=64'h55 the same cycle; undefined, valA keeps the old value until after the posedge.
- Reset reasserted at INIT cycle 6 -> sweep restarts; ready rises 15 cycles after the final reset deassertion; a write attempted during INIT is lost.
